ctrl_serializer: RTL and testbench
==================================

CTRL_SERIALIZER -- requirements
Module: ctrl_serializer

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode width; only 6 is supported.
REQ-002 SHALL have parameter WORD_W, default 13, decoded control-word width; only 13 is supported.
REQ-003 SHALL have parameter BIT_DIV, default 1, clock cycles per serial bit; legal range 1..65535.
REQ-004 SHALL have parameter GAP_BITS, default 2, idle bit-times between frames; legal range 0..255.
REQ-005 SHALL have port clk_16mhz  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  opcode offered.
REQ-008 SHALL have port in_opcode  input  OPCODE_W  instruction opcode field.
REQ-009 SHALL have port in_ready  output  1  block can accept an opcode.
REQ-010 SHALL have port ser_data  output  1  serial control-word bit, LSB first.
REQ-011 SHALL have port ser_frame  output  1  high while a frame bit (data or parity) is on ser_data.
REQ-012 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-013 SHALL have port word_out  output  WORD_W  last accepted decoded word.
REQ-014 SHALL have port illegal  output  1  sticky flag: an undefined opcode was accepted.

Function
REQ-015 Word field order, MSB..LSB, SHALL be: regdst, jal, jmp, branch, bne, memread, memtoreg, aluop[2:0], memwrite, alusrc, regwrite.
REQ-016 Decode SHALL be combinational from in_opcode via the package table; undefined opcodes SHALL decode to all-ones.
REQ-017 FSM states SHALL be IDLE, SHIFT, GAP; in_ready = (state==IDLE) and not rst.
REQ-018 Transfer SHALL occur on a cycle with in_valid and in_ready both high; in_opcode is sampled only then.
REQ-019 On transfer: decoded word loads into shift register and word_out; illegal sets if the opcode is undefined; state -> SHIFT.
REQ-020 First bit (word bit 0) SHALL appear on ser_data, with ser_frame=1, the cycle after transfer.
REQ-021 Each frame bit SHALL be held exactly BIT_DIV cycles, via a bit-period counter and a bit index counter.
REQ-022 After the last frame bit: state -> GAP if GAP_BITS>0, else -> IDLE.
REQ-023 GAP SHALL last GAP_BITS*BIT_DIV cycles with ser_data=0 and ser_frame=0, then -> IDLE.
REQ-024 Back-to-back: with in_valid held high and GAP_BITS=0, the next transfer SHALL occur in the first IDLE cycle after the frame.
REQ-025 In IDLE, ser_data=0 and ser_frame=0; in_valid while not ready SHALL be ignored, with no state change.
REQ-026 illegal SHALL clear only on rst.

Reset
REQ-027 rst SHALL force, on the next edge: state=IDLE, all counters=0, shift register=0, ser_data=0, ser_frame=0, busy=0, word_out=0, illegal=0.
REQ-028 rst mid-frame SHALL abort the frame immediately; no further frame bits are emitted.
REQ-029 in_ready SHALL be 0 while rst is high and 1 on the first cycle after rst deasserts.

Configuration
REQ-030 Macro CTRL_SER_PARITY_EN defined: frame SHALL be WORD_W data bits plus one even-parity bit (XOR of the word) with ser_frame=1, so total WORD_W+1 bits.
REQ-031 Macro CTRL_SER_PARITY_EN undefined: frame SHALL be exactly WORD_W bits and no parity logic is present.

Structure
REQ-032 Package ctrl_pkg SHALL hold the opcode localparams, field bit positions, FSM state typedef, and the decode table constants.
REQ-033 Sub-module ctrl_decode SHALL hold the combinational opcode-to-word decode; the table is R-type 000000=0x1011, lw 100011=0x0C3, beq 000100=0x208, others per package.

Verification
REQ-034 rst, then opcode 000000 with BIT_DIV=1, parity off -> word_out=0x1011; ser_data cycles 1..13 = bits 1,0,0,0,1,0,0,0,0,0,0,0,1; busy for 13+GAP_BITS cycles.
REQ-035 Opcode 100011 with BIT_DIV=3 -> each bit held 3 cycles; ser_frame high for exactly 39 cycles.
REQ-036 Opcode 111110 (undefined) -> word_out=0x1FFF, illegal=1 and stays 1 through the next legal frame until rst.
REQ-037 CTRL_SER_PARITY_EN, opcode 000100 (0x208, popcount 2) -> 14th frame bit=0; opcode 000000 (popcount 3) -> 14th bit=1.
REQ-038 rst asserted at frame bit 5 -> the next cycle shows all outputs 0, in_ready=0; in_ready=1 the cycle after rst drops.
REQ-039 GAP_BITS=0, in_valid held high with two opcodes -> the second frame's bit 0 appears with exactly one non-frame (IDLE) cycle between frames.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the control-word serializer: opcodes, word field
// positions, decode table values and FSM state type.
package ctrl_pkg;

   localparam int OPC_W = 6;
   localparam int CW_W  = 13;

   localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
   localparam logic [OPC_W-1:0] OP_JAL   = 6'b000011;
   localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;

   // Word bit positions, LSB first.
   localparam int F_REGWRITE = 0;
   localparam int F_ALUSRC   = 1;
   localparam int F_MEMWRITE = 2;
   localparam int F_ALUOP_LO = 3;
   localparam int F_ALUOP_HI = 5;
   localparam int F_MEMTOREG = 6;
   localparam int F_MEMREAD  = 7;
   localparam int F_BNE      = 8;
   localparam int F_BRANCH   = 9;
   localparam int F_JMP      = 10;
   localparam int F_JAL      = 11;
   localparam int F_REGDST   = 12;

   localparam logic [CW_W-1:0] W_RTYPE   = 13'h1011;
   localparam logic [CW_W-1:0] W_J       = 13'h0400;
   localparam logic [CW_W-1:0] W_JAL     = 13'h0801;
   localparam logic [CW_W-1:0] W_BEQ     = 13'h0208;
   localparam logic [CW_W-1:0] W_BNE     = 13'h0108;
   localparam logic [CW_W-1:0] W_ADDI    = 13'h0003;
   localparam logic [CW_W-1:0] W_LW      = 13'h00C3;
   localparam logic [CW_W-1:0] W_SW      = 13'h0006;
   localparam logic [CW_W-1:0] W_ILLEGAL = 13'h1FFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control-word decode; undefined opcodes give
// all-ones plus an undef flag.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [OPC_W-1:0] opcode_i,
   output logic [CW_W-1:0]  word_o,
   output logic             undef_o
);

   always_comb begin
      word_o  = W_ILLEGAL;
      undef_o = 1'b0;
      case (opcode_i)
         OP_RTYPE: word_o = W_RTYPE;
         OP_J:     word_o = W_J;
         OP_JAL:   word_o = W_JAL;
         OP_BEQ:   word_o = W_BEQ;
         OP_BNE:   word_o = W_BNE;
         OP_ADDI:  word_o = W_ADDI;
         OP_LW:    word_o = W_LW;
         OP_SW:    word_o = W_SW;
         default:  undef_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_serializer.sv
// Decodes an accepted opcode and shifts the control word out LSB first.
// Define CTRL_SER_PARITY_EN to append an even-parity bit to each frame.
module ctrl_serializer
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int WORD_W   = 13,
   parameter int BIT_DIV  = 1,
   parameter int GAP_BITS = 2
) (
   input  logic                clk_16mhz,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [OPCODE_W-1:0] in_opcode,
   output logic                in_ready,
   output logic                ser_data,
   output logic                ser_frame,
   output logic                busy,
   output logic [WORD_W-1:0]   word_out,
   output logic                illegal
);

`ifdef CTRL_SER_PARITY_EN
   localparam int FRAME_BITS = WORD_W + 1;
`else
   localparam int FRAME_BITS = WORD_W;
`endif
   localparam logic [15:0] PER_LAST   = 16'(BIT_DIV - 1);
   localparam logic [7:0]  FRAME_LAST = 8'(FRAME_BITS - 1);
   localparam logic [7:0]  GAP_LAST   = 8'(GAP_BITS - 1);

   state_e                  state_q, state_d;
   logic [15:0]             per_q, per_d;
   logic [7:0]              idx_q, idx_d;
   logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
   logic [WORD_W-1:0]       word_q, word_d;
   logic                    ill_q, ill_d;
   logic [WORD_W-1:0]       dec_word;
   logic                    dec_undef;
   logic [FRAME_BITS-1:0]   load_val;
   logic                    xfer;

   ctrl_decode u_decode (
      .opcode_i (in_opcode),
      .word_o   (dec_word),
      .undef_o  (dec_undef)
   );

`ifdef CTRL_SER_PARITY_EN
   assign load_val = {^dec_word, dec_word};
`else
   assign load_val = dec_word;
`endif

   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign xfer      = in_valid && in_ready;
   assign ser_frame = (state_q == ST_SHIFT);
   assign ser_data  = ser_frame && shreg_q[0];
   assign busy      = (state_q != ST_IDLE);
   assign word_out  = word_q;
   assign illegal   = ill_q;

   // per counts cycles within a bit-time; idx counts frame or gap bits.
   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      word_d  = word_q;
      ill_d   = ill_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               shreg_d = load_val;
               word_d  = dec_word;
               ill_d   = ill_q | dec_undef;
               per_d   = '0;
               idx_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (per_q == PER_LAST) begin
               per_d   = '0;
               shreg_d = shreg_q >> 1;
               if (idx_q == FRAME_LAST) begin
                  idx_d   = '0;
                  state_d = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end else begin
               per_d = per_q + 16'd1;
            end
         end
         ST_GAP: begin
            if (per_q == PER_LAST) begin
               per_d = '0;
               if (idx_q == GAP_LAST) begin
                  idx_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end else begin
               per_d = per_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_16mhz) begin
      if (rst) begin
         state_q <= ST_IDLE;
         per_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         word_q  <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         word_q  <= word_d;
         ill_q   <= ill_d;
      end
   end

endmodule

// File: tb/tb_ctrl_serializer.sv
// Bench for ctrl_serializer: two instances (BIT_DIV=1/GAP=2 and
// BIT_DIV=3/GAP=0) checked against a field-level reference model.
module tb_ctrl_serializer;

`ifdef CTRL_SER_PARITY_EN
   localparam int FB = 14;
`else
   localparam int FB = 13;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       in_valid;
   logic [1:0][5:0]  in_opcode;
   logic [1:0]       in_ready, ser_data, ser_frame, busy, illegal;
   logic [1:0][12:0] word_out;

   int checks = 0;
   int errors = 0;
   int bd [2] = '{1, 3};
   int gp [2] = '{2, 0};
   logic ill_m [2];
   logic [5:0] defined_ops [8] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100,
                                   6'b000101, 6'b001000, 6'b100011, 6'b101011};

   always #5 clk = ~clk;

   ctrl_serializer #(.OPCODE_W(6), .WORD_W(13), .BIT_DIV(1), .GAP_BITS(2)) u0 (
      .clk_16mhz(clk), .rst(rst), .in_valid(in_valid[0]), .in_opcode(in_opcode[0]),
      .in_ready(in_ready[0]), .ser_data(ser_data[0]), .ser_frame(ser_frame[0]),
      .busy(busy[0]), .word_out(word_out[0]), .illegal(illegal[0]));

   ctrl_serializer #(.OPCODE_W(6), .WORD_W(13), .BIT_DIV(3), .GAP_BITS(0)) u1 (
      .clk_16mhz(clk), .rst(rst), .in_valid(in_valid[1]), .in_opcode(in_opcode[1]),
      .in_ready(in_ready[1]), .ser_data(ser_data[1]), .ser_frame(ser_frame[1]),
      .busy(busy[1]), .word_out(word_out[1]), .illegal(illegal[1]));

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decode from the named control fields; bit 13 = undefined.
   function automatic logic [13:0] ref_dec(input logic [5:0] op);
      logic regdst = 0, jal = 0, jmp = 0, branch = 0, bne = 0, memread = 0;
      logic memtoreg = 0, memwrite = 0, alusrc = 0, regwrite = 0;
      logic [2:0] aluop = 3'd0;
      case (op)
         6'b000000: begin regdst = 1; aluop = 3'd2; regwrite = 1; end
         6'b100011: begin memread = 1; memtoreg = 1; alusrc = 1; regwrite = 1; end
         6'b101011: begin memwrite = 1; alusrc = 1; end
         6'b000100: begin branch = 1; aluop = 3'd1; end
         6'b000101: begin bne = 1; aluop = 3'd1; end
         6'b000010: jmp = 1;
         6'b000011: begin jal = 1; regwrite = 1; end
         6'b001000: begin alusrc = 1; regwrite = 1; end
         default: return {1'b1, 13'h1FFF};
      endcase
      return {1'b0, regdst, jal, jmp, branch, bne, memread, memtoreg, aluop,
              memwrite, alusrc, regwrite};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int d);
      int n = 0;
      while (!in_ready[d] && n < 200) begin
         tick();
         n++;
      end
      chk($sformatf("ready_wait%0d", d), 32'(n < 200), 32'd1);
   endtask

   // Offers op on instance d, then checks every cycle of frame and gap.
   task automatic run_frame(input int d, input logic [5:0] op, input bit hold);
      logic [13:0] r;
      logic [13:0] bits;
      r = ref_dec(op);
      bits = {^r[12:0], r[12:0]};
      in_opcode[d] = op;
      in_valid[d] = 1'b1;
      wait_ready(d);
      tick();
      if (!hold) in_valid[d] = 1'b0;
      ill_m[d] = ill_m[d] | r[13];
      chk($sformatf("word_out%0d op%b", d, op), 32'(word_out[d]), 32'(r[12:0]));
      chk($sformatf("illegal%0d", d), 32'(illegal[d]), 32'(ill_m[d]));
      for (int b = 0; b < FB; b++) begin
         for (int k = 0; k < bd[d]; k++) begin
            chk($sformatf("frame%0d b%0d", d, b), 32'(ser_frame[d]), 32'd1);
            chk($sformatf("data%0d b%0d", d, b), 32'(ser_data[d]), 32'(bits[b]));
            chk($sformatf("busy%0d b%0d", d, b), 32'(busy[d]), 32'd1);
            tick();
         end
      end
      for (int g = 0; g < gp[d] * bd[d]; g++) begin
         chk($sformatf("gap_frame%0d", d), 32'(ser_frame[d]), 32'd0);
         chk($sformatf("gap_data%0d", d), 32'(ser_data[d]), 32'd0);
         chk($sformatf("gap_busy%0d", d), 32'(busy[d]), 32'd1);
         tick();
      end
      chk($sformatf("idle_busy%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("idle_frame%0d", d), 32'(ser_frame[d]), 32'd0);
      chk($sformatf("idle_data%0d", d), 32'(ser_data[d]), 32'd0);
      chk($sformatf("idle_ready%0d", d), 32'(in_ready[d]), 32'd1);
      chk($sformatf("idle_word%0d", d), 32'(word_out[d]), 32'(r[12:0]));
   endtask

   task automatic chk_reset_outs(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_ready%0d", tag, d), 32'(in_ready[d]), 32'd0);
         chk($sformatf("%s_busy%0d", tag, d), 32'(busy[d]), 32'd0);
         chk($sformatf("%s_frame%0d", tag, d), 32'(ser_frame[d]), 32'd0);
         chk($sformatf("%s_data%0d", tag, d), 32'(ser_data[d]), 32'd0);
         chk($sformatf("%s_word%0d", tag, d), 32'(word_out[d]), 32'd0);
         chk($sformatf("%s_ill%0d", tag, d), 32'(illegal[d]), 32'd0);
      end
   endtask

   initial begin
      logic [5:0] op;
      int d;
      rst = 1'b1;
      in_valid = '0;
      in_opcode = '0;
      ill_m[0] = 1'b0;
      ill_m[1] = 1'b0;
      repeat (3) tick();
      chk_reset_outs("reset");
      rst = 1'b0;
      #1;
      chk("ready_after_rst0", 32'(in_ready[0]), 32'd1);
      chk("ready_after_rst1", 32'(in_ready[1]), 32'd1);

      // R-type at BIT_DIV=1, then lw at BIT_DIV=3
      run_frame(0, 6'b000000, 0);
      chk("rtype_literal", 32'(word_out[0]), 32'h1011);
      run_frame(1, 6'b100011, 0);
      chk("lw_literal", 32'(word_out[1]), 32'h00C3);

      // undefined opcode sets sticky illegal, which survives a legal frame
      run_frame(0, 6'b111110, 0);
      chk("undef_literal", 32'(word_out[0]), 32'h1FFF);
      chk("undef_ill", 32'(illegal[0]), 32'd1);
      run_frame(0, 6'b000100, 0);
      chk("ill_sticky", 32'(illegal[0]), 32'd1);
      run_frame(0, 6'b000000, 0);

      // back-to-back on the GAP_BITS=0 instance with valid held
      run_frame(1, 6'b100011, 1);
      in_opcode[1] = 6'b000100;
      run_frame(1, 6'b000100, 0);

      for (int i = 0; i < 12; i++) begin
         d = int'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) op = defined_ops[$urandom_range(0, 7)];
         else op = 6'($urandom);
         run_frame(d, op, 0);
      end

      // reset while bit 5 of a frame is on the line
      in_opcode[0] = 6'b000000;
      in_valid[0] = 1'b1;
      wait_ready(0);
      tick();
      in_valid[0] = 1'b0;
      repeat (5) tick();
      chk("bit5_frame", 32'(ser_frame[0]), 32'd1);
      rst = 1'b1;
      ill_m[0] = 1'b0;
      ill_m[1] = 1'b0;
      tick();
      chk_reset_outs("midrst");
      tick();
      chk("midrst_hold_frame", 32'(ser_frame[0]), 32'd0);
      rst = 1'b0;
      #1;
      chk("midrst_ready", 32'(in_ready[0]), 32'd1);
      repeat (3) begin
         tick();
         chk("post_rst_frame", 32'(ser_frame[0]), 32'd0);
      end
      run_frame(0, 6'b101011, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
